systolic_ctrl: RTL

Sequencer and stream front end for the `size`×`size` weight-stationary systolic array. It buffers one weight matrix from a valid/ready weight port and programs it into the array as `size` back-to-back `set_w` cycles. It then accepts input vectors on a valid/ready port, applies the per-lane input skew the array requires, and deskews the array's column outputs into one aligned result vector with a valid flag. It sits between the layer scheduler and the array instance and owns all array control.

---
 rtl/systolic_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: buffers one weight matrix, programs it into a Size x Size
// weight-stationary systolic array, skews input vectors into the array rows
// and deskews the column outputs into one aligned, tagged result vector.
module systolic_ctrl #(
    parameter int DataSize = 16,
    parameter int Size     = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     w_valid_i,
    output logic                     w_ready_o,
    input  logic [DataSize*Size-1:0] w_data_i,
    input  logic                     x_valid_i,
    output logic                     x_ready_o,
    input  logic [DataSize*Size-1:0] x_data_i,
    output logic                     y_valid_o,
    output logic [DataSize*Size-1:0] y_data_o,
    output logic                     weights_loaded_o,
    output logic                     busy_o,
    output logic [DataSize*Size-1:0] arr_data_stream_o,
    output logic [DataSize*Size-1:0] arr_w_stream_o,
    output logic                     arr_set_w_o,
    input  logic [DataSize*Size-1:0] arr_y_stream_i
);

    localparam int CntW    = (Size > 1) ? $clog2(Size) : 1;
    localparam int FlightW = $clog2(2 * Size + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(Size - 1);

    typedef enum logic [2:0] {
        StEmpty,
        StCollect,
        StProgram,
        StReady,
        StDrain
    } state_e;

    state_e                     state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [DataSize*Size-1:0]   wbuf_q [Size];
    logic [FlightW-1:0]         inflight_q;
    logic [2*Size-1:0]          tag_q;
    logic                       x_accept;

    assign x_accept         = x_valid_i && x_ready_o;
    assign weights_loaded_o = (state_q == StReady) || (state_q == StDrain);
    assign busy_o           = ((state_q != StReady) && (state_q != StEmpty)) || (inflight_q != '0);
    assign y_valid_o        = tag_q[2*Size-1];

    // Controller state and the shared beat/program-row counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and handshake/array control; ready is never offered while programming or draining.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        w_ready_o      = 1'b0;
        x_ready_o      = 1'b0;
        arr_set_w_o    = 1'b0;
        arr_w_stream_o = '0;
        case (state_q)
            StEmpty: begin
                if (w_valid_i) state_d = StCollect;
            end
            StCollect: begin
                w_ready_o = 1'b1;
                if (w_valid_i) begin
                    if (cnt_q == LastIdx) begin
                        cnt_d   = '0;
                        state_d = StProgram;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StProgram: begin
                arr_set_w_o    = 1'b1;
                arr_w_stream_o = wbuf_q[cnt_q];
                if (cnt_q == LastIdx) begin
                    cnt_d   = '0;
                    state_d = StReady;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReady: begin
                x_ready_o = !w_valid_i;
                if (w_valid_i) state_d = StDrain;
            end
            StDrain: begin
                if (inflight_q == '0) state_d = StCollect;
            end
            default: state_d = StEmpty;
        endcase
    end

    // Weight buffer, one row per accepted beat, held until the next collection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Size; i++) wbuf_q[i] <= '0;
        end else if ((state_q == StCollect) && w_valid_i) begin
            wbuf_q[cnt_q] <= w_data_i;
        end
    end

    // Vectors between accept and result, so the matrix is never swapped under live data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= '0;
        end else begin
            case ({x_accept, y_valid_o})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Valid tag travels alongside the data through skew, array and deskew.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tag_q <= '0;
        else         tag_q <= {tag_q[2*Size-2:0], x_accept};
    end

    for (genvar r = 0; r < Size; r++) begin : g_skew
        logic [DataSize-1:0] stage_q [r+1];

        // Row r input delayed r+1 cycles; idle cycles push zeros into the array.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int j = 0; j <= r; j++) stage_q[j] <= '0;
            end else begin
                stage_q[0] <= x_accept ? x_data_i[(Size-r)*DataSize-1 -: DataSize] : '0;
                for (int j = 1; j <= r; j++) stage_q[j] <= stage_q[j-1];
            end
        end

        assign arr_data_stream_o[(Size-r)*DataSize-1 -: DataSize] = stage_q[r];
    end

    for (genvar c = 0; c < Size; c++) begin : g_deskew
        localparam int Depth = Size - c;
        logic [DataSize-1:0] stage_q [Depth];

        // Column c delayed Size-c cycles so every lane of a result lines up.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int j = 0; j < Depth; j++) stage_q[j] <= '0;
            end else begin
                stage_q[0] <= arr_y_stream_i[(Size-c)*DataSize-1 -: DataSize];
                for (int j = 1; j < Depth; j++) stage_q[j] <= stage_q[j-1];
            end
        end

        assign y_data_o[(Size-c)*DataSize-1 -: DataSize] = stage_q[Depth-1];
    end

endmodule
